// File: rtl/ahblite_lcd_ctrl.sv
// ahblite_lcd_ctrl: AHB-Lite slave feeding a FIFO-buffered 8080-style LCD write sequencer
module ahblite_lcd_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TIMING_RST = 8'h22
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        LCD_CS,
    output logic        LCD_RS,
    output logic        LCD_WR,
    output logic        LCD_RD,
    output logic        LCD_RST,
    output logic        LCD_BL_CTR,
    output logic [15:0] LCD_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WRL   = 2'd2;
    localparam logic [1:0] S_WRH   = 2'd3;

    logic          r_wr, r_rd;
    logic [2:0]    r_off;
    logic [1:0]    r_ctrl;
    logic [7:0]    r_timing;
    logic [16:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_lvl;
    logic [1:0]    r_st;
    logic [3:0]    r_tmr;
    logic          r_cs, r_rs, r_wrn;
    logic [15:0]   r_data;

    logic          w_full, w_empty, w_push_ph, w_push, w_pop, w_wdone, w_busy;
    logic [3:0]    w_tl, w_th;
    logic [16:0]   w_head;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_full    = r_lvl == (AW+1)'(FIFO_DEPTH);
    assign w_empty   = r_lvl == '0;
    assign w_push_ph = r_wr & (r_off[2:1] == 2'b00);
    assign HREADYOUT = ~(w_push_ph & w_full);
    assign w_push    = w_push_ph & ~w_full;
    assign w_wdone   = r_wr & HREADYOUT;
    assign w_tl      = (r_timing[3:0] == 4'd0) ? 4'd1 : r_timing[3:0];
    assign w_th      = (r_timing[7:4] == 4'd0) ? 4'd1 : r_timing[7:4];
    assign w_head    = r_mem[r_rp];
    assign w_pop     = ~w_empty & ((r_st == S_IDLE) | ((r_st == S_WRH) & (r_tmr == 4'd0)));
    assign w_busy    = ~w_empty | (r_st != S_IDLE);
    assign w_status  = 32'({r_lvl, w_full, w_busy});
    assign w_unused  = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign HRESP      = 1'b0;
    assign LCD_RD     = 1'b1;
    assign LCD_CS     = r_cs;
    assign LCD_RS     = r_rs;
    assign LCD_WR     = r_wrn;
    assign LCD_DATA   = r_data;
    assign LCD_RST    = r_ctrl[0];
    assign LCD_BL_CTR = r_ctrl[1];

    // read data is driven from the registered address during the data phase
    always_comb begin
        HRDATA = ~r_rd           ? 32'd0 :
                 (r_off == 3'd2) ? {30'd0, r_ctrl} :
                 (r_off == 3'd3) ? {24'd0, r_timing} :
                 (r_off == 3'd4) ? w_status : 32'd0;
    end

    // capture the address phase; held while the bus is stalled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_off <= 3'd0;
        end else if (HREADY) begin
            r_wr  <= HSEL & HTRANS[1] & HWRITE;
            r_rd  <= HSEL & HTRANS[1] & ~HWRITE;
            r_off <= HADDR[4:2];
        end
    end

    // CTRL and TIMING registers, written when the data phase completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ctrl   <= 2'd0;
            r_timing <= TIMING_RST;
        end else begin
            if (w_wdone && r_off == 3'd2) r_ctrl <= HWDATA[1:0];
            if (w_wdone && r_off == 3'd3) r_timing <= HWDATA[7:0];
        end
    end

    // FIFO storage; bit 16 carries RS (0 = command, 1 = data)
    always_ff @(posedge HCLK) begin
        if (w_push) r_mem[r_wp] <= {r_off[0], HWDATA[15:0]};
    end

    // FIFO pointers and fill level
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_lvl <= r_lvl + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // write sequencer: SETUP, WR low for TL cycles, WR high for TH cycles
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_st   <= S_IDLE;
            r_tmr  <= 4'd0;
            r_cs   <= 1'b1;
            r_rs   <= 1'b1;
            r_wrn  <= 1'b1;
            r_data <= 16'd0;
        end else begin
            case (r_st)
                S_IDLE: if (w_pop) begin
                    r_st   <= S_SETUP;
                    r_cs   <= 1'b0;
                    r_rs   <= w_head[16];
                    r_data <= w_head[15:0];
                end
                S_SETUP: begin
                    r_st  <= S_WRL;
                    r_wrn <= 1'b0;
                    r_tmr <= w_tl - 4'd1;
                end
                S_WRL: if (r_tmr == 4'd0) begin
                    r_st  <= S_WRH;
                    r_wrn <= 1'b1;
                    r_tmr <= w_th - 4'd1;
                end else begin
                    r_tmr <= r_tmr - 4'd1;
                end
                default: if (r_tmr != 4'd0) begin
                    r_tmr <= r_tmr - 4'd1;
                end else if (w_pop) begin
                    r_st   <= S_SETUP;
                    r_rs   <= w_head[16];
                    r_data <= w_head[15:0];
                end else begin
                    r_st <= S_IDLE;
                    r_cs <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahblite_lcd_ctrl.sv
// tb_ahblite_lcd_ctrl: scoreboard bench comparing LCD write waveforms against queued expectations
module tb_ahblite_lcd_ctrl;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic [3:0]  HPROT = 4'd3;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
    logic [15:0] LCD_DATA;

    typedef struct packed {
        logic        rs;
        logic [15:0] d;
        int          tl;
        int          th;
    } wexp_t;

    wexp_t q[$];
    int n_cmp = 0, n_fail = 0;
    logic [7:0] cur_timing = 8'h22;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahblite_lcd_ctrl dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
        .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR), .LCD_DATA(LCD_DATA)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output int stall);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        stall = 0;
        @(negedge HCLK);
        while (!HREADYOUT && stall < 200) begin
            stall++;
            @(negedge HCLK);
        end
        if (stall >= 200) chk("write_stall_timeout", 32'(stall), 32'd0);
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic push_word(input logic rs, input logic [15:0] d, output int stall);
        wexp_t e;
        e.rs = rs;
        e.d  = d;
        e.tl = (cur_timing[3:0] == 0) ? 1 : int'(cur_timing[3:0]);
        e.th = (cur_timing[7:4] == 0) ? 1 : int'(cur_timing[7:4]);
        q.push_back(e);
        ahb_write(rs ? 32'h4 : 32'h0, {16'hDEAD, d}, stall);
    endtask

    task automatic set_timing(input logic [7:0] t);
        int s;
        ahb_write(32'hC, {24'hABCDEF, t}, s);
        cur_timing = t;
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        int k = 0;
        ahb_read(32'h10, st);
        while (st != 0 && k < 400) begin
            ahb_read(32'h10, st);
            k++;
        end
        chk("status_idle", st, 32'd0);
    endtask

    task automatic wait_wr_low();
        int k = 0;
        @(negedge HCLK);
        while (LCD_WR && k < 100) begin
            @(negedge HCLK);
            k++;
        end
        chk("wr_low_seen", 32'(LCD_WR), 32'd0);
        @(posedge HCLK); #1;
    endtask

    // waveform monitor: checks each WR pulse against the head of the expectation queue
    logic pw = 1'b1, pc = 1'b1, ar = 1'b0;
    int   lo = 0, hi = 0, lth = 0;
    always @(negedge HCLK) begin
        wexp_t e;
        if (!HRESETn) begin
            pw = 1'b1; pc = 1'b1; ar = 1'b0; lo = 0; hi = 0;
        end else begin
            if (!LCD_CS && !LCD_WR) lo++;
            if (pw && !LCD_WR) begin
                chk("cs_at_wr_fall", 32'(LCD_CS), 32'd0);
                if (ar) chk("wr_high_in_burst", 32'(hi), 32'(lth + 1));
                ar = 1'b0;
            end
            if (!pw && LCD_WR) begin
                if (q.size() == 0) begin
                    chk("unexpected_wr_pulse", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("lcd_rs", 32'(LCD_RS), 32'(e.rs));
                    chk("lcd_data", 32'(LCD_DATA), 32'(e.d));
                    chk("wr_low_width", 32'(lo), 32'(e.tl));
                    lth = e.th;
                    ar = 1'b1;
                end
                lo = 0;
                hi = 1;
            end else if (ar && LCD_WR && !LCD_CS) begin
                hi++;
            end
            if (ar && !pc && LCD_CS) begin
                chk("wr_high_last", 32'(hi), 32'(lth));
                ar = 1'b0;
            end
            pw = LCD_WR;
            pc = LCD_CS;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int s, s5, s6;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_cs", 32'(LCD_CS), 32'd1);
        chk("rst_rs", 32'(LCD_RS), 32'd1);
        chk("rst_wr", 32'(LCD_WR), 32'd1);
        chk("rst_rd", 32'(LCD_RD), 32'd1);
        chk("rst_lcdrst", 32'(LCD_RST), 32'd0);
        chk("rst_bl", 32'(LCD_BL_CTR), 32'd0);
        chk("rst_data", 32'(LCD_DATA), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(32'h10, rd); chk("status_after_reset", rd, 32'd0);
        ahb_read(32'hC, rd);  chk("timing_reset", rd, 32'h22);
        ahb_read(32'h8, rd);  chk("ctrl_reset", rd, 32'd0);

        // single command write with exact edge checks
        push_word(1'b0, 16'h002C, s);
        @(negedge HCLK); chk("e0_cs_high", 32'(LCD_CS), 32'd1);
        @(negedge HCLK);
        chk("e1_cs_low", 32'(LCD_CS), 32'd0);
        chk("e1_wr_high", 32'(LCD_WR), 32'd1);
        chk("e1_rs", 32'(LCD_RS), 32'd0);
        chk("e1_data", 32'(LCD_DATA), 32'h2C);
        @(negedge HCLK); chk("e2_wr_low", 32'(LCD_WR), 32'd0);
        @(posedge HCLK); #1;
        wait_idle();

        // burst of six data words; slow timing forces the sixth push to stall
        set_timing(8'h88);
        for (int i = 1; i <= 6; i++) begin
            push_word(1'b1, 16'(i), s);
            if (i == 5) s5 = s;
            if (i == 6) s6 = s;
        end
        chk("burst_push5_nostall", 32'(s5), 32'd0);
        chk("burst_push6_stalled", 32'(s6 != 0), 32'd1);
        wait_idle();

        // minimum timing (zero fields act as one) and asymmetric timing
        set_timing(8'h00);
        for (int i = 0; i < 3; i++) push_word(i[0], 16'hA5A0 + 16'(i), s);
        wait_idle();
        set_timing(8'hF3);
        push_word(1'b1, 16'h1234, s);
        push_word(1'b0, 16'h4321, s);
        wait_idle();

        // CTRL write mid-transfer, then undefined and write-only reads
        set_timing(8'h22);
        push_word(1'b1, 16'hBEEF, s);
        push_word(1'b1, 16'hCAFE, s);
        wait_wr_low();
        ahb_write(32'h8, 32'h3, s);
        chk("ctrl_lcd_rst", 32'(LCD_RST), 32'd1);
        chk("ctrl_bl", 32'(LCD_BL_CTR), 32'd1);
        ahb_read(32'h8, rd);  chk("ctrl_read", rd, 32'h3);
        ahb_read(32'h14, rd); chk("undef_read", rd, 32'd0);
        ahb_read(32'h4, rd);  chk("data_reg_read", rd, 32'd0);
        wait_idle();

        // randomized words with randomized timing per batch
        for (int b = 0; b < 5; b++) begin
            set_timing(8'($urandom_range(0, 255)) & 8'h57);
            for (int i = 0; i < 8; i++) push_word(1'($urandom), 16'($urandom), s);
            wait_idle();
        end

        // reset during WR low with three words queued
        set_timing(8'hFF);
        for (int i = 0; i < 4; i++) push_word(1'b1, 16'h7000 + 16'(i), s);
        wait_wr_low();
        HRESETn = 1'b0;
        q.delete();
        cur_timing = 8'h22;
        @(negedge HCLK);
        chk("arst_cs", 32'(LCD_CS), 32'd1);
        chk("arst_wr", 32'(LCD_WR), 32'd1);
        chk("arst_rs", 32'(LCD_RS), 32'd1);
        chk("arst_data", 32'(LCD_DATA), 32'd0);
        chk("arst_lcdrst", 32'(LCD_RST), 32'd0);
        chk("arst_bl", 32'(LCD_BL_CTR), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        repeat (80) @(posedge HCLK);
        #1;
        ahb_read(32'h10, rd); chk("arst_status", rd, 32'd0);
        ahb_read(32'hC, rd);  chk("arst_timing", rd, 32'h22);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
